// File: rtl/mem_pkg.sv
// Shared op encodings and FSM state type for sync_memory_ctrl.
package mem_pkg;
  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RESP  = 2'd1,
    CLEAR = 2'd2
  } state_t;
endpackage

// File: rtl/sync_mem_word.sv
// One storage word with sync reset, clear and write enable.
// With MEM_PARITY_EN defined, also holds a parity bit supplied by the parent.
module sync_mem_word #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_we,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_wdata,
`ifdef MEM_PARITY_EN
  input  logic             i_par,
  output logic             o_par,
`endif
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (!rst_n)     r_q <= '0;
    else if (i_clr) r_q <= '0;
    else if (i_we)  r_q <= i_wdata;
  end

`ifdef MEM_PARITY_EN
  logic r_par;
  // A cleared word is all zeros, so parity 0 is consistent with it.
  always_ff @(posedge clk) begin
    if (!rst_n)     r_par <= 1'b0;
    else if (i_clr) r_par <= 1'b0;
    else if (i_we)  r_par <= i_par;
  end
  assign o_par = r_par;
`endif

  assign o_q = r_q;
endmodule

// File: rtl/sync_memory_ctrl.sv
// DEPTH x WIDTH register memory behind valid/ready request and response channels.
// Optional per-word even parity with error injection under MEM_PARITY_EN.
module sync_memory_ctrl
  import mem_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
`ifdef MEM_PARITY_EN
  input  logic                   par_inject,
`endif
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [1:0]             req_op,
  input  logic [AW-1:0]          req_addr,
  input  logic [WIDTH-1:0]       req_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WIDTH-1:0]       rsp_rdata,
  output logic                   rsp_err,
  output logic                   busy,
  output logic [DEPTH*WIDTH-1:0] stored_value
);
  state_t           r_state, w_state_nx;
  logic [AW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rdata, w_rdata_nx;
  logic             r_err, w_err_nx;

  logic             w_accept, w_addr_ok, w_cnt_last, w_par_bad;
  logic [WIDTH-1:0] w_rd_word;
  logic [DEPTH-1:0] w_we, w_clr;
  logic [WIDTH-1:0] w_q [DEPTH];

  assign req_ready  = (r_state == IDLE);
  assign rsp_valid  = (r_state == RESP);
  assign busy       = (r_state == CLEAR);
  assign rsp_rdata  = r_rdata;
  assign rsp_err    = r_err;

  assign w_accept   = req_valid && req_ready;
  // DEPTH need not be a power of two, so the top addresses may be unmapped.
  assign w_addr_ok  = (32'(req_addr) < 32'(DEPTH));
  assign w_cnt_last = (r_cnt == AW'(DEPTH-1));

`ifdef MEM_PARITY_EN
  logic w_par_in;
  logic w_par [DEPTH];
  logic w_rd_par;
  assign w_par_in = (^req_wdata) ^ par_inject;
`endif

  for (genvar j = 0; j < DEPTH; j++) begin : g_word
    assign w_we[j]  = w_accept && (req_op == OP_WRITE) && w_addr_ok && (req_addr == AW'(j));
    assign w_clr[j] = (r_state == CLEAR) && (r_cnt == AW'(j));

    sync_mem_word #(.WIDTH(WIDTH)) u_word (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_we    (w_we[j]),
      .i_clr   (w_clr[j]),
      .i_wdata (req_wdata),
`ifdef MEM_PARITY_EN
      .i_par   (w_par_in),
      .o_par   (w_par[j]),
`endif
      .o_q     (w_q[j])
    );

    assign stored_value[j*WIDTH +: WIDTH] = w_q[j];
  end

  always_comb begin
    w_rd_word = '0;
`ifdef MEM_PARITY_EN
    w_rd_par  = 1'b0;
`endif
    for (int j = 0; j < DEPTH; j++) begin
      if (req_addr == AW'(j)) begin
        w_rd_word = w_q[j];
`ifdef MEM_PARITY_EN
        w_rd_par  = w_par[j];
`endif
      end
    end
  end

`ifdef MEM_PARITY_EN
  assign w_par_bad = (^w_rd_word) != w_rd_par;
`else
  assign w_par_bad = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    w_rdata_nx = r_rdata;
    w_err_nx   = r_err;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nx = RESP;
          case (req_op)
            OP_READ: begin
              w_rdata_nx = w_addr_ok ? w_rd_word : '0;
              w_err_nx   = !w_addr_ok || w_par_bad;
            end
            OP_WRITE: begin
              w_rdata_nx = req_wdata;
              w_err_nx   = !w_addr_ok;
            end
            OP_CLEAR: begin
              w_state_nx = CLEAR;
              w_rdata_nx = '0;
              w_err_nx   = 1'b0;
            end
            default: begin
              w_rdata_nx = '0;
              w_err_nx   = 1'b1;
            end
          endcase
        end
      end
      RESP: begin
        if (rsp_ready) w_state_nx = IDLE;
      end
      CLEAR: begin
        if (w_cnt_last) begin
          w_state_nx = RESP;
          w_rdata_nx = '0;
          w_err_nx   = 1'b0;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_rdata <= w_rdata_nx;
      r_err   <= w_err_nx;
      r_cnt   <= ((r_state == CLEAR) && !w_cnt_last) ? r_cnt + 1'b1 : '0;
    end
  end
endmodule

// File: tb/tb_sync_memory_ctrl.sv
// Randomised bench for sync_memory_ctrl: a DEPTH=8 and a DEPTH=6 instance against an array model.
module tb_sync_memory_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       vld  [2];
  logic [1:0] opr  [2];
  logic [2:0] adr  [2];
  logic [7:0] wdat [2];
  logic       rr   [2];
  logic       pinj [2];
  logic       rdy  [2];
  logic       rv   [2];
  logic       er   [2];
  logic       bz   [2];
  logic [7:0] rd   [2];
  logic [63:0] sv  [2];
  logic [63:0] sv8;
  logic [47:0] sv6;
  assign sv[0] = sv8;
  assign sv[1] = {16'h0, sv6};

`ifdef MEM_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  sync_memory_ctrl #(.WIDTH(8), .DEPTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n),
`ifdef MEM_PARITY_EN
    .par_inject(pinj[0]),
`endif
    .req_valid(vld[0]), .req_ready(rdy[0]), .req_op(opr[0]), .req_addr(adr[0]),
    .req_wdata(wdat[0]), .rsp_valid(rv[0]), .rsp_ready(rr[0]), .rsp_rdata(rd[0]),
    .rsp_err(er[0]), .busy(bz[0]), .stored_value(sv8)
  );

  sync_memory_ctrl #(.WIDTH(8), .DEPTH(6)) u_dut6 (
    .clk(clk), .rst_n(rst_n),
`ifdef MEM_PARITY_EN
    .par_inject(pinj[1]),
`endif
    .req_valid(vld[1]), .req_ready(rdy[1]), .req_op(opr[1]), .req_addr(adr[1]),
    .req_wdata(wdat[1]), .rsp_valid(rv[1]), .rsp_ready(rr[1]), .rsp_rdata(rd[1]),
    .rsp_err(er[1]), .busy(bz[1]), .stored_value(sv6)
  );

  int         total = 0;
  int         bad   = 0;
  int         dep [2] = '{8, 6};
  logic [7:0] mdl  [2][8];
  logic       pbad [2][8];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] exp_sv(input int d);
    logic [63:0] r = '0;
    for (int a = 0; a < dep[d]; a++) r[a*8 +: 8] = mdl[d][a];
    return r;
  endfunction

  task automatic model_zero();
    for (int d = 0; d < 2; d++)
      for (int a = 0; a < 8; a++) begin mdl[d][a] = 8'h0; pbad[d][a] = 1'b0; end
  endtask

  // One complete transaction: accept, response with optional backpressure, handshake.
  task automatic issue(input int d, input logic [1:0] op, input logic [2:0] a,
                       input logic [7:0] wd, input logic inj, input int hold);
    int t;
    logic [7:0] ed;
    logic ee;
    bit ok;
    ok = (int'(a) < dep[d]);
    case (op)
      2'b00: begin ed = ok ? mdl[d][a] : 8'h0; ee = !ok || pbad[d][a]; end
      2'b01: begin
        ed = wd; ee = !ok;
        if (ok) begin mdl[d][a] = wd; pbad[d][a] = inj & PAR_ON; end
      end
      2'b10: begin
        ed = 8'h0; ee = 1'b0;
        for (int i = 0; i < 8; i++) begin mdl[d][i] = 8'h0; pbad[d][i] = 1'b0; end
      end
      default: begin ed = 8'h0; ee = 1'b1; end
    endcase

    @(negedge clk);
    t = 0;
    while (!rdy[d] && t < 100) begin @(negedge clk); t++; end
    chk("req_ready", 64'(rdy[d]), 64'd1);
    vld[d] = 1'b1; opr[d] = op; adr[d] = a; wdat[d] = wd; pinj[d] = inj;
    @(posedge clk);
    #1 vld[d] = 1'b0; pinj[d] = 1'b0;
    @(negedge clk);

    if (op == 2'b10) begin
      t = 0;
      while (bz[d] && t < 50) begin
        if (rv[d] || rdy[d]) chk("clear_idle_outs", {rv[d], rdy[d]}, 2'b00);
        t++;
        @(negedge clk);
      end
      chk("clear_cycles", 64'(t), 64'(dep[d]));
    end
    chk("rsp_latency", 64'(rv[d]), 64'd1);

    for (int h = 0; h < hold; h++) begin
      chk("hold_state", {rv[d], rdy[d], er[d], rd[d]}, {1'b1, 1'b0, ee, ed});
      @(negedge clk);
    end
    chk("rsp_rdata", 64'(rd[d]), 64'(ed));
    chk("rsp_err", 64'(er[d]), 64'(ee));
    rr[d] = 1'b1;
    @(posedge clk);
    #1 rr[d] = 1'b0;
    @(negedge clk);
    chk("post_hs", {rv[d], rdy[d]}, 2'b01);
    chk("stored", sv[d], exp_sv(d));
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      vld[d] = 1'b0; opr[d] = 2'b00; adr[d] = 3'd0; wdat[d] = 8'h0; rr[d] = 1'b0; pinj[d] = 1'b0;
    end
    model_zero();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset_outs", {rdy[d], rv[d], bz[d], er[d], rd[d]}, {1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
      chk("reset_stored", sv[d], 64'h0);
    end

    issue(0, 2'b00, 3'd3, 8'h00, 1'b0, 0);
    issue(0, 2'b01, 3'd5, 8'hA5, 1'b0, 0);
    issue(0, 2'b00, 3'd5, 8'h00, 1'b0, 0);
    chk("word5", sv[0], 64'h0000_A500_0000_0000);
    issue(0, 2'b00, 3'd2, 8'h00, 1'b0, 4);

    for (int a = 0; a < 8; a++) issue(0, 2'b01, 3'(a), 8'hFF, 1'b0, 0);
    chk("all_ff", sv[0], 64'hFFFF_FFFF_FFFF_FFFF);
    issue(0, 2'b10, 3'd0, 8'h00, 1'b0, 1);
    chk("cleared", sv[0], 64'h0);

    for (int a = 0; a < 8; a++) issue(0, 2'b01, 3'(a), 8'hFF, 1'b0, 0);
    issue(1, 2'b01, 3'd4, 8'h5A, 1'b0, 0);
    @(negedge clk);
    vld[0] = 1'b1; opr[0] = 2'b10;
    @(posedge clk);
    #1 vld[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_clear_busy", 64'(bz[0]), 64'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_zero();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_mid_clear", {bz[d], rdy[d], rv[d]}, 3'b010);
      chk("rst_mid_stored", sv[d], 64'h0);
    end

    issue(1, 2'b01, 3'd2, 8'h11, 1'b0, 0);
    issue(1, 2'b01, 3'd7, 8'h3C, 1'b0, 0);
    issue(1, 2'b00, 3'd6, 8'h00, 1'b0, 2);
    issue(1, 2'b11, 3'd1, 8'h77, 1'b0, 0);
    issue(0, 2'b11, 3'd0, 8'h77, 1'b0, 1);
    issue(1, 2'b10, 3'd0, 8'h00, 1'b0, 0);

`ifdef MEM_PARITY_EN
    issue(0, 2'b01, 3'd1, 8'h0F, 1'b1, 0);
    issue(0, 2'b00, 3'd1, 8'h00, 1'b0, 0);
    issue(0, 2'b01, 3'd1, 8'h0F, 1'b0, 0);
    issue(0, 2'b00, 3'd1, 8'h00, 1'b0, 0);
`endif

    for (int n = 0; n < 200; n++) begin
      int d, r;
      logic [1:0] op;
      d = int'($urandom_range(0, 1));
      r = int'($urandom_range(0, 19));
      op = (r < 8) ? 2'b00 : (r < 16) ? 2'b01 : (r < 18) ? 2'b11 : 2'b10;
      issue(d, op, 3'($urandom_range(0, 7)), 8'($urandom), 1'($urandom_range(0, 3) == 0),
            int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
